// File: rtl/fit_wb_pkg.sv
// Shared constants and FSM state type for the fitness writeback block.
package fit_wb_pkg;
  localparam int FIT_W    = 10;
  localparam int POP_SIZE = 50;
  localparam int IDX_W    = 6;

  localparam logic [FIT_W-1:0] FIT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;
endpackage

// File: rtl/fit_top2_tracker.sv
// Tracks the two lowest energies of a generation and their indices.
// Ties keep the earlier index; the first word after i_clear always fills second.
module fit_top2_tracker #(
  parameter int FIT_W = fit_wb_pkg::FIT_W,
  parameter int IDX_W = fit_wb_pkg::IDX_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [FIT_W-1:0] i_energy,
  input  logic [IDX_W-1:0] i_index,
  output logic [FIT_W-1:0] o_best_energy,
  output logic [IDX_W-1:0] o_best_idx,
  output logic [FIT_W-1:0] o_second_energy,
  output logic [IDX_W-1:0] o_second_idx
);
  import fit_wb_pkg::*;

  logic [FIT_W-1:0] r_best_energy;
  logic [IDX_W-1:0] r_best_idx;
  logic [FIT_W-1:0] r_second_energy;
  logic [IDX_W-1:0] r_second_idx;
  // Second slot is empty until a real word lands in it, so an all-ones word still counts.
  logic             r_sec_vld;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_best_energy   <= '1;
      r_best_idx      <= '0;
      r_second_energy <= '1;
      r_second_idx    <= '0;
      r_sec_vld       <= 1'b0;
    end else if (i_clear) begin
      r_best_energy   <= i_valid ? i_energy : '1;
      r_best_idx      <= i_valid ? i_index : '0;
      r_second_energy <= '1;
      r_second_idx    <= '0;
      r_sec_vld       <= 1'b0;
    end else if (i_valid) begin
      if (i_energy < r_best_energy) begin
        r_second_energy <= r_best_energy;
        r_second_idx    <= r_best_idx;
        r_sec_vld       <= 1'b1;
        r_best_energy   <= i_energy;
        r_best_idx      <= i_index;
      end else if (!r_sec_vld || (i_energy < r_second_energy)) begin
        r_second_energy <= i_energy;
        r_second_idx    <= i_index;
        r_sec_vld       <= 1'b1;
      end
    end
  end

  assign o_best_energy   = r_best_energy;
  assign o_best_idx      = r_best_idx;
  assign o_second_energy = r_second_energy;
  assign o_second_idx    = r_second_idx;
endmodule

// File: rtl/fitness_writeback.sv
// Stores one generation of energies, tracks the two best, and hands off to selection.
// Optional running energy sum output enabled by defining FIT_WB_SUM_EN.
module fitness_writeback #(
  parameter int FIT_W    = fit_wb_pkg::FIT_W,
  parameter int POP_SIZE = fit_wb_pkg::POP_SIZE,
  parameter int IDX_W    = fit_wb_pkg::IDX_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fit_valid_i,
  input  logic [FIT_W-1:0] fit_energy_i,
  input  logic             fit_buf_sel_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_addr_i,
  output logic [FIT_W-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic [FIT_W-1:0] best_energy_o,
  output logic [IDX_W-1:0] best_idx_o,
  output logic [FIT_W-1:0] second_energy_o,
  output logic [IDX_W-1:0] second_idx_o,
  output logic             gen_done_o,
  input  logic             sel_ack_i,
  output logic             buf_sel_o,
  output logic             busy_o,
  output logic             err_o
`ifdef FIT_WB_SUM_EN
  ,
  output logic [FIT_W+IDX_W-1:0] sum_energy_o
`endif
);
  import fit_wb_pkg::*;

  localparam int MEM_AW = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1;
  localparam int MEM_D  = 1 << MEM_AW;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POP_SIZE - 1);
  localparam logic [IDX_W:0]   POP_LIM  = (IDX_W + 1)'(POP_SIZE);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_wr_cnt;
  logic             r_buf_sel;
  logic             r_err;
  logic             r_rd_valid;
  logic [FIT_W-1:0] r_rd_data;
  logic [FIT_W-1:0] r_mem [MEM_D];

  logic w_start;
  logic w_accept;
  logic w_tag_err;
  logic w_drop_err;
  logic w_addr_err;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_accept     = 1'b0;
    w_tag_err    = 1'b0;
    w_drop_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (fit_valid_i) begin
          w_start      = 1'b1;
          w_accept     = 1'b1;
          w_state_next = (POP_SIZE == 1) ? REPORT : COLLECT;
        end
      end
      COLLECT: begin
        if (fit_valid_i) begin
          w_accept  = 1'b1;
          w_tag_err = (fit_buf_sel_i != r_buf_sel);
          if (r_wr_cnt == LAST_IDX) begin
            w_state_next = REPORT;
          end
        end
      end
      REPORT: begin
        // Words arriving here, including one coincident with the ack, are dropped.
        w_drop_err = fit_valid_i;
        if (sel_ack_i) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_addr_err = rd_en_i && ({1'b0, rd_addr_i} >= POP_LIM);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_wr_cnt  <= '0;
      r_buf_sel <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_buf_sel <= fit_buf_sel_i;
      end
      if (w_accept) begin
        r_wr_cnt <= (r_wr_cnt == LAST_IDX) ? '0 : r_wr_cnt + 1'b1;
      end
      if (w_tag_err || w_drop_err || w_addr_err) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_mem[r_wr_cnt[MEM_AW-1:0]] <= fit_energy_i;
    end
  end

  // Registered read sees the pre-write contents on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_en_i;
      if (rd_en_i) begin
        r_rd_data <= w_addr_err ? '0 : r_mem[rd_addr_i[MEM_AW-1:0]];
      end
    end
  end

  fit_top2_tracker #(
    .FIT_W(FIT_W),
    .IDX_W(IDX_W)
  ) u_tracker (
    .i_clk          (clk_i),
    .i_rst          (rst_i),
    .i_clear        (w_start),
    .i_valid        (w_accept),
    .i_energy       (fit_energy_i),
    .i_index        (r_wr_cnt),
    .o_best_energy  (best_energy_o),
    .o_best_idx     (best_idx_o),
    .o_second_energy(second_energy_o),
    .o_second_idx   (second_idx_o)
  );

`ifdef FIT_WB_SUM_EN
  logic [FIT_W+IDX_W-1:0] r_sum;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sum <= '0;
    end else if (w_start) begin
      r_sum <= {{IDX_W{1'b0}}, fit_energy_i};
    end else if (w_accept) begin
      r_sum <= r_sum + {{IDX_W{1'b0}}, fit_energy_i};
    end
  end

  assign sum_energy_o = r_sum;
`endif

  assign rd_data_o  = r_rd_data;
  assign rd_valid_o = r_rd_valid;
  assign gen_done_o = (r_state == REPORT);
  assign busy_o     = (r_state != IDLE);
  assign buf_sel_o  = r_buf_sel;
  assign err_o      = r_err;
endmodule

// File: tb/tb_fitness_writeback.sv
// Bench for fitness_writeback: directed table, randomized run against a reference model,
// and a full POP_SIZE=50 generation on a second instance.
module tb_fitness_writeback;
  localparam int P = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- small instance (POP_SIZE=4) ----------------
  logic       rst_i, fit_valid_i, fit_buf_sel_i, rd_en_i, sel_ack_i;
  logic [9:0] fit_energy_i;
  logic [5:0] rd_addr_i;
  logic [9:0] rd_data_o, best_energy_o, second_energy_o;
  logic [5:0] best_idx_o, second_idx_o;
  logic       rd_valid_o, gen_done_o, buf_sel_o, busy_o, err_o;
`ifdef FIT_WB_SUM_EN
  logic [15:0] sum_energy_o;
`endif

  fitness_writeback #(.FIT_W(10), .POP_SIZE(P), .IDX_W(6)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .fit_valid_i(fit_valid_i), .fit_energy_i(fit_energy_i),
    .fit_buf_sel_i(fit_buf_sel_i), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .best_energy_o(best_energy_o),
    .best_idx_o(best_idx_o), .second_energy_o(second_energy_o), .second_idx_o(second_idx_o),
    .gen_done_o(gen_done_o), .sel_ack_i(sel_ack_i), .buf_sel_o(buf_sel_o),
    .busy_o(busy_o), .err_o(err_o)
`ifdef FIT_WB_SUM_EN
    , .sum_energy_o(sum_energy_o)
`endif
  );

  // ---------------- big instance (POP_SIZE=50) ----------------
  logic       b_rst, b_valid, b_tag, b_rd, b_ack;
  logic [9:0] b_energy;
  logic [5:0] b_addr;
  logic [9:0] b_rdata, b_be, b_se;
  logic [5:0] b_bi, b_si;
  logic       b_rdv, b_done, b_bs, b_busy, b_err;
`ifdef FIT_WB_SUM_EN
  logic [15:0] b_sum;
`endif

  fitness_writeback #(.FIT_W(10), .POP_SIZE(50), .IDX_W(6)) u_big (
    .clk_i(clk), .rst_i(b_rst), .fit_valid_i(b_valid), .fit_energy_i(b_energy),
    .fit_buf_sel_i(b_tag), .rd_en_i(b_rd), .rd_addr_i(b_addr),
    .rd_data_o(b_rdata), .rd_valid_o(b_rdv), .best_energy_o(b_be),
    .best_idx_o(b_bi), .second_energy_o(b_se), .second_idx_o(b_si),
    .gen_done_o(b_done), .sel_ack_i(b_ack), .buf_sel_o(b_bs),
    .busy_o(b_busy), .err_o(b_err)
`ifdef FIT_WB_SUM_EN
    , .sum_energy_o(b_sum)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_phase = 0;   // 0 waiting, 1 collecting, 2 generation reported
  bit         m_tag = 0;
  bit         m_err = 0;
  bit         m_rdv = 0;
  logic [9:0] m_rdd = 0;
  bit         m_rd_known = 1;
  logic [9:0] m_store [P];
  bit         m_known [P];
  int         m_gen [$];

  task automatic model_step(input bit rst, input bit v, input logic [9:0] e, input bit tag,
                            input bit rd, input logic [5:0] a, input bit ack);
    if (rst) begin
      m_phase = 0; m_tag = 0; m_err = 0; m_rdv = 0; m_rdd = 0; m_rd_known = 1;
      m_gen.delete();
      return;
    end
    m_rdv = rd;
    if (rd) begin
      if (a >= P) begin
        m_rdd = 0; m_rd_known = 1; m_err = 1;
      end else begin
        m_rdd = m_store[a]; m_rd_known = m_known[a];
      end
    end
    if (m_phase == 0) begin
      if (v) begin
        m_gen.delete(); m_gen.push_back(int'(e));
        m_store[0] = e; m_known[0] = 1; m_tag = tag; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (v) begin
        if (tag != m_tag) m_err = 1;
        m_store[m_gen.size()] = e; m_known[m_gen.size()] = 1;
        m_gen.push_back(int'(e));
        if (m_gen.size() == P) m_phase = 2;
      end
    end else begin
      if (v) m_err = 1;
      if (ack) m_phase = 0;
    end
  endtask

  // Lowest energy (earliest on ties), then lowest of the rest (earliest on ties).
  task automatic ref_top2(output int be, output int bi, output int se, output int si);
    bi = 0;
    for (int i = 1; i < m_gen.size(); i++) if (m_gen[i] < m_gen[bi]) bi = i;
    be = m_gen[bi];
    si = -1;
    for (int i = 0; i < m_gen.size(); i++)
      if (i != bi && (si < 0 || m_gen[i] < m_gen[si])) si = i;
    if (si < 0) begin se = 1023; si = 0; end
    else se = m_gen[si];
  endtask

  task automatic model_check();
    int be, bi, se, si, sum;
    chk("gen_done", gen_done_o, m_phase == 2);
    chk("busy", busy_o, m_phase != 0);
    chk("err", err_o, m_err);
    chk("buf_sel", buf_sel_o, m_tag);
    chk("rd_valid", rd_valid_o, m_rdv);
    if (m_rd_known) chk("rd_data", rd_data_o, m_rdd);
    if (m_phase == 2) begin
      ref_top2(be, bi, se, si);
      chk("best_energy", best_energy_o, be);
      chk("best_idx", best_idx_o, bi);
      chk("second_energy", second_energy_o, se);
      chk("second_idx", second_idx_o, si);
      sum = 0;
      foreach (m_gen[i]) sum += m_gen[i];
`ifdef FIT_WB_SUM_EN
      chk("sum_energy", sum_energy_o, sum);
`endif
    end
  endtask

  task automatic cycle(input bit rst, input bit v, input logic [9:0] e, input bit tag,
                       input bit rd, input logic [5:0] a, input bit ack);
    rst_i = rst; fit_valid_i = v; fit_energy_i = e; fit_buf_sel_i = tag;
    rd_en_i = rd; rd_addr_i = a; sel_ack_i = ack;
    @(posedge clk);
    model_step(rst, v, e, tag, rd, a, ack);
    #1;
    model_check();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit rst; bit v; logic [9:0] e; bit tag; bit rd; logic [5:0] a; bit ack;
    bit x_done; bit x_err; bit x_bs;
    bit c_tr; logic [9:0] x_be; logic [5:0] x_bi; logic [9:0] x_se; logic [5:0] x_si;
    bit c_rd; logic [9:0] x_rd;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input bit rst, input bit v, input logic [9:0] e, input bit tag,
                     input bit rd, input logic [5:0] a, input bit ack,
                     input bit x_done, input bit x_err, input bit x_bs);
    vec_t r;
    r = '{default: 0};
    r.rst = rst; r.v = v; r.e = e; r.tag = tag; r.rd = rd; r.a = a; r.ack = ack;
    r.x_done = x_done; r.x_err = x_err; r.x_bs = x_bs;
    vecs.push_back(r);
  endtask

  task automatic add_tr(input logic [9:0] be, input logic [5:0] bi,
                        input logic [9:0] se, input logic [5:0] si);
    vec_t r;
    r = vecs.pop_back();
    r.c_tr = 1; r.x_be = be; r.x_bi = bi; r.x_se = se; r.x_si = si;
    vecs.push_back(r);
  endtask

  task automatic add_rd(input logic [9:0] d);
    vec_t r;
    r = vecs.pop_back();
    r.c_rd = 1; r.x_rd = d;
    vecs.push_back(r);
  endtask

  initial begin
    b_rst = 1; b_valid = 0; b_energy = 0; b_tag = 0; b_rd = 0; b_addr = 0; b_ack = 0;
    for (int i = 0; i < P; i++) begin m_store[i] = 0; m_known[i] = 0; end

    // reset state
    add(1,0,0,0,0,0,0, 0,0,0); add_tr(10'h3FF,0,10'h3FF,0);
    add(0,0,0,0,0,0,0, 0,0,0);
    // 7,3,3,9 back-to-back
    add(0,1,7,0,0,0,0, 0,0,0); add(0,1,3,0,0,0,0, 0,0,0);
    add(0,1,3,0,0,0,0, 0,0,0); add(0,1,9,0,0,0,0, 1,0,0); add_tr(3,1,3,2);
    add(0,0,0,0,0,0,1, 0,0,0);
    // 5,4,3,2 with gaps, then read back
    add(0,1,5,0,0,0,0, 0,0,0); add(0,0,0,0,0,0,0, 0,0,0);
    add(0,1,4,0,0,0,0, 0,0,0); add(0,0,0,0,0,0,0, 0,0,0);
    add(0,1,3,0,0,0,0, 0,0,0); add(0,0,0,0,0,0,0, 0,0,0);
    add(0,1,2,0,0,0,0, 1,0,0); add_tr(2,3,3,2);
    add(0,0,0,0,1,0,0, 1,0,0); add_rd(5);
    add(0,0,0,0,1,1,0, 1,0,0); add_rd(4);
    add(0,0,0,0,1,2,0, 1,0,0); add_rd(3);
    add(0,0,0,0,1,3,0, 1,0,0); add_rd(2); add_tr(2,3,3,2);
    // extra word in REPORT is dropped
    add(0,1,1,0,0,0,0, 1,1,0); add_tr(2,3,3,2);
    add(0,0,0,0,1,0,0, 1,1,0); add_rd(5);
    add(0,0,0,0,1,3,0, 1,1,0); add_rd(2);
    // abort mid-generation, then 8,8,8,8
    add(1,0,0,0,0,0,0, 0,0,0); add_tr(10'h3FF,0,10'h3FF,0);
    add(0,1,6,1,0,0,0, 0,0,1); add(0,1,6,1,0,0,0, 0,0,1);
    add(1,0,0,0,0,0,0, 0,0,0);
    add(0,1,8,0,0,0,0, 0,0,0); add(0,1,8,0,0,0,0, 0,0,0);
    add(0,1,8,0,0,0,0, 0,0,0); add(0,1,8,0,0,0,0, 1,0,0); add_tr(8,0,8,1);
    // ack, next generation right after with tag 1
    add(0,0,0,0,0,0,1, 0,0,0);
    add(0,1,1,1,0,0,0, 0,0,1); add(0,1,0,1,0,0,0, 0,0,1);
    add(0,1,1,1,0,0,0, 0,0,1); add(0,1,1,1,0,0,0, 1,0,1); add_tr(0,1,1,0);
    // out-of-range read, valid coincident with ack, store untouched
    add(0,0,0,0,1,5,0, 1,1,1); add_rd(0);
    add(0,1,7,1,0,0,1, 0,1,1);
    add(0,0,0,0,1,0,0, 0,1,1); add_rd(1);
    add(1,0,0,0,0,0,0, 0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].v, vecs[i].e, vecs[i].tag, vecs[i].rd, vecs[i].a, vecs[i].ack);
      chk($sformatf("row%0d_done", i), gen_done_o, vecs[i].x_done);
      chk($sformatf("row%0d_err", i), err_o, vecs[i].x_err);
      chk($sformatf("row%0d_bufsel", i), buf_sel_o, vecs[i].x_bs);
      chk($sformatf("row%0d_rdvalid", i), rd_valid_o, vecs[i].c_rd);
      if (vecs[i].c_rd) chk($sformatf("row%0d_rddata", i), rd_data_o, vecs[i].x_rd);
      if (vecs[i].c_tr) begin
        chk($sformatf("row%0d_best_e", i), best_energy_o, vecs[i].x_be);
        chk($sformatf("row%0d_best_i", i), best_idx_o, vecs[i].x_bi);
        chk($sformatf("row%0d_sec_e", i), second_energy_o, vecs[i].x_se);
        chk($sformatf("row%0d_sec_i", i), second_idx_o, vecs[i].x_si);
      end
    end

    // ---------------- randomized run ----------------
    for (int n = 0; n < 800; n++) begin
      bit         r_rst, r_v, r_tag, r_rd, r_ack;
      logic [9:0] r_e;
      logic [5:0] r_a;
      r_rst = ($urandom_range(0, 149) == 0);
      r_v   = $urandom_range(0, 1) == 1;
      r_e   = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
      if (m_phase == 0) r_tag = $urandom_range(0, 1) == 1;
      else              r_tag = ($urandom_range(0, 39) == 0) ? ~m_tag : m_tag;
      r_rd  = $urandom_range(0, 1) == 1;
      r_a   = ($urandom_range(0, 29) == 0) ? 6'($urandom_range(4, 63)) : 6'($urandom_range(0, 3));
      r_ack = (m_phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      cycle(r_rst, r_v, r_e, r_tag, r_rd, r_a, r_ack);
    end
    cycle(1, 0, 0, 0, 0, 0, 0);

    // ---------------- POP_SIZE=50, all 1023 ----------------
    @(posedge clk); #1;
    b_rst = 0;
    chk("big_reset_done", b_done, 0);
    chk("big_reset_best", b_be, 10'h3FF);
    b_valid = 1; b_energy = 10'h3FF; b_tag = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (i == 48) chk("big_done_early", b_done, 0);
    end
    b_valid = 0;
    chk("big_done", b_done, 1);
    chk("big_busy", b_busy, 1);
    chk("big_err", b_err, 0);
    chk("big_best_e", b_be, 1023);
    chk("big_best_i", b_bi, 0);
    chk("big_sec_e", b_se, 1023);
    chk("big_sec_i", b_si, 1);
`ifdef FIT_WB_SUM_EN
    chk("big_sum", b_sum, 51150);
`endif
    b_rd = 1; b_addr = 49;
    @(posedge clk); #1;
    chk("big_rd49", b_rdata, 1023);
    b_rd = 0; b_ack = 1;
    @(posedge clk); #1;
    b_ack = 0;
    chk("big_done_after_ack", b_done, 0);
    chk("big_busy_after_ack", b_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
